// File: rtl/ultra_scheduler.sv
// Round-robin sequencer for HC-SR04-style ultrasonic rangers sharing one scan engine.
// Fires one trigger at a time, times the synchronised echo, and stores cm results per channel.
module ultra_scheduler #(
    parameter int NUM_SENSORS   = 4,
    parameter int TRIG_CYCLES   = 500,
    parameter int CYCLES_PER_CM = 2900,
    parameter int ECHO_TIMEOUT  = 1500000,
    parameter int GUARD_CYCLES  = 3000000,
    localparam int ID_W = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NUM_SENSORS-1:0] sensor_mask,
    input  logic [NUM_SENSORS-1:0] echo,
    output logic [NUM_SENSORS-1:0] trigger,
    input  logic [ID_W-1:0]        rd_sel,
    output logic [15:0]            rd_distance,
    output logic [1:0]             rd_status,
    output logic                   sample_done,
    output logic [ID_W-1:0]        sample_id,
    output logic                   busy
);

    localparam int MAX_A    = (TRIG_CYCLES > ECHO_TIMEOUT) ? TRIG_CYCLES : ECHO_TIMEOUT;
    localparam int MAX_CYC  = (MAX_A > GUARD_CYCLES) ? MAX_A : GUARD_CYCLES;
    localparam int TMR_W    = $clog2(MAX_CYC + 1);
    localparam int SUB_W    = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;
    localparam int RD_DEPTH = 1 << ID_W;

    localparam logic [TMR_W-1:0] TRIG_LAST  = TMR_W'(TRIG_CYCLES - 1);
    localparam logic [TMR_W-1:0] ECHO_LAST  = TMR_W'(ECHO_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] GUARD_LAST = TMR_W'(GUARD_CYCLES - 1);
    localparam logic [SUB_W-1:0] SUB_LAST   = SUB_W'(CYCLES_PER_CM - 1);
    localparam logic [15:0]      CM_MAX     = 16'hFFFE;
    localparam logic [15:0]      NO_DATA    = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_GUARD
    } state_t;

    state_t                 state, state_n;
    logic [ID_W-1:0]        idx, idx_n, pick;
    logic [TMR_W-1:0]       timer, timer_n;
    logic [SUB_W-1:0]       sub_cnt, sub_n, sub_step;
    logic [15:0]            cm_cnt, cm_n, cm_step;
    logic [NUM_SENSORS-1:0] echo_meta, echo_sync, trig_n;
    logic                   echo_sel, scan_go;
    logic                   wr_en, wr_valid, wr_fault;
    logic [15:0]            wr_dist;
    int                     cand;

    logic [15:0]            dist_mem [NUM_SENSORS];
    logic [NUM_SENSORS-1:0] valid_mem, fault_mem;
    logic [15:0]            rd_dist_tab [RD_DEPTH];
    logic [1:0]             rd_stat_tab [RD_DEPTH];

    assign echo_sel = echo_sync[idx];
    assign scan_go  = enable && (sensor_mask != '0);
    assign busy     = (state != S_IDLE);

    // Next enabled channel strictly after idx; descending k lets the nearest one win.
    always_comb begin
        pick = idx;
        cand = 0;
        for (int k = NUM_SENSORS; k >= 1; k--) begin
            cand = int'(idx) + k;
            if (cand >= NUM_SENSORS) cand = cand - NUM_SENSORS;
            if (sensor_mask[cand[ID_W-1:0]]) pick = cand[ID_W-1:0];
        end
    end

    always_comb begin
        if (sub_cnt == SUB_LAST) begin
            sub_step = '0;
            cm_step  = (cm_cnt == CM_MAX) ? cm_cnt : cm_cnt + 16'd1;
        end else begin
            sub_step = sub_cnt + SUB_W'(1);
            cm_step  = cm_cnt;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_n  = state;
        idx_n    = idx;
        timer_n  = timer + TMR_W'(1);
        sub_n    = sub_cnt;
        cm_n     = cm_cnt;
        wr_en    = 1'b0;
        wr_valid = 1'b0;
        wr_fault = 1'b0;
        wr_dist  = NO_DATA;
        case (state)
            S_IDLE: begin
                timer_n = '0;
                if (scan_go) begin
                    state_n = S_TRIG;
                    idx_n   = pick;
                end
            end
            S_TRIG: begin
                sub_n = '0;
                cm_n  = '0;
                if (timer == TRIG_LAST) begin
                    state_n = S_WAIT_RISE;
                    timer_n = '0;
                end
            end
            S_WAIT_RISE: begin
                if (timer == '0 && echo_sel) begin
                    wr_en    = 1'b1;
                    wr_fault = 1'b1;
                end else if (timer == ECHO_LAST) begin
                    wr_en = 1'b1;
                end else if (echo_sel) begin
                    state_n = S_MEASURE;
                    sub_n   = sub_step;
                    cm_n    = cm_step;
                end
            end
            S_MEASURE: begin
                // A fall in the timeout cycle still yields a valid reading.
                if (!echo_sel) begin
                    wr_en    = 1'b1;
                    wr_valid = 1'b1;
                    wr_dist  = cm_cnt;
                end else if (timer == ECHO_LAST) begin
                    wr_en = 1'b1;
                end else begin
                    sub_n = sub_step;
                    cm_n  = cm_step;
                end
            end
            S_GUARD: begin
                if (timer == GUARD_LAST) begin
                    timer_n = '0;
                    if (scan_go) begin
                        state_n = S_TRIG;
                        idx_n   = pick;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (wr_en) begin
            state_n = S_GUARD;
            timer_n = '0;
        end
    end

    always_comb begin
        trig_n = '0;
        if (state_n == S_TRIG) trig_n[idx_n] = 1'b1;
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            idx         <= ID_W'(NUM_SENSORS - 1);
            timer       <= '0;
            sub_cnt     <= '0;
            cm_cnt      <= '0;
            echo_meta   <= '0;
            echo_sync   <= '0;
            trigger     <= '0;
            sample_done <= 1'b0;
            sample_id   <= '0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            timer       <= timer_n;
            sub_cnt     <= sub_n;
            cm_cnt      <= cm_n;
            echo_meta   <= echo;
            echo_sync   <= echo_meta;
            trigger     <= trig_n;
            sample_done <= wr_en;
            if (wr_en) sample_id <= idx;
        end
    end

    // NOTE: the result store is reset on purpose, so readback shows "no data" right after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dist_mem  <= '{default: NO_DATA};
            valid_mem <= '0;
            fault_mem <= '0;
        end else if (wr_en) begin
            dist_mem[idx]  <= wr_dist;
            valid_mem[idx] <= wr_valid;
            fault_mem[idx] <= wr_fault;
        end
    end

    // Readback table padded to a power of two; unused selects read as zero.
    for (genvar g = 0; g < RD_DEPTH; g++) begin : g_rd
        if (g < NUM_SENSORS) begin : g_live
            assign rd_dist_tab[g] = dist_mem[g];
            assign rd_stat_tab[g] = {fault_mem[g], valid_mem[g]};
        end else begin : g_pad
            assign rd_dist_tab[g] = '0;
            assign rd_stat_tab[g] = '0;
        end
    end

    assign rd_distance = rd_dist_tab[rd_sel];
    assign rd_status   = rd_stat_tab[rd_sel];

endmodule

// File: tb/tb_ultra_scheduler.sv
// Randomised bench for ultra_scheduler with a channel-order and result model kept in the bench.
// Echo responses are generated per ping; expected results and latencies come from the block's rules.
module tb_ultra_scheduler;

    localparam int NS  = 4;
    localparam int TC  = 4;
    localparam int CPC = 10;
    localparam int ET  = 200;
    localparam int GC  = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [NS-1:0] sensor_mask;
    logic [NS-1:0] echo;
    logic [NS-1:0] trigger;
    logic [1:0]    rd_sel;
    logic [15:0]   rd_distance;
    logic [1:0]    rd_status;
    logic          sample_done;
    logic [1:0]    sample_id;
    logic          busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int m_cur;
    int last_trig_cyc;
    int last_done_cyc;
    logic [15:0] m_dist [NS];
    logic [1:0]  m_stat [NS];

    ultra_scheduler #(
        .NUM_SENSORS  (NS),
        .TRIG_CYCLES  (TC),
        .CYCLES_PER_CM(CPC),
        .ECHO_TIMEOUT (ET),
        .GUARD_CYCLES (GC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .sensor_mask(sensor_mask),
        .echo       (echo),
        .trigger    (trigger),
        .rd_sel     (rd_sel),
        .rd_distance(rd_distance),
        .rd_status  (rd_status),
        .sample_done(sample_done),
        .sample_id  (sample_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    function automatic int next_ch(input int cur, input logic [NS-1:0] m);
        for (int k = 1; k <= NS; k++)
            if (m[(cur + k) % NS]) return (cur + k) % NS;
        return -1;
    endfunction

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; sensor_mask = '0; echo = '0; rd_sel = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NS; i++) begin m_dist[i] = 16'hFFFF; m_stat[i] = 2'b00; end
        m_cur = NS - 1;
    endtask

    task automatic read_all_results(input string tag);
        for (int ch = 0; ch < NS; ch++) begin
            rd_sel = 2'(ch);
            #1;
            total++;
            if (rd_distance !== m_dist[ch] || rd_status !== m_stat[ch]) begin
                bad++;
                $display("FAIL %s ch%0d: got %h/%b want %h/%b", tag, ch, rd_distance, rd_status, m_dist[ch], m_stat[ch]);
            end
        end
    endtask

    task automatic wait_trigger(output int ch, output int at_cyc);
        ch = -1; at_cyc = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (trigger !== '0) begin
                for (int j = 0; j < NS; j++) if (trigger[j]) ch = j;
                at_cyc = cyc;
                break;
            end
        end
        total++;
        if (ch < 0 || $countones(trigger) != 1) begin
            bad++;
            $display("FAIL trigger_wait: got trigger=%b want exactly one bit high", trigger);
        end
    endtask

    // kind: 0 = echo pulse of len cycles after d cycles, 1 = silent echo, 2 = echo already stuck high
    task automatic ping(input int kind, input int d, input int len, input bit drop_en);
        int exp_ch, ch, t_cyc, w_cyc, width, exp_lat;
        logic [15:0] ed;
        logic [1:0]  es;
        bit seen;
        exp_ch = next_ch(m_cur, sensor_mask);
        wait_trigger(ch, t_cyc);
        last_trig_cyc = t_cyc;
        total++;
        if (ch !== exp_ch) begin bad++; $display("FAIL order: got ch%0d want ch%0d", ch, exp_ch); end
        if (ch < 0) return;
        m_cur = ch;
        width = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (trigger === (4'b0001 << ch)) width++;
            else break;
        end
        total++;
        if (width != TC || trigger !== '0) begin
            bad++;
            $display("FAIL trig_width ch%0d: got %0d cycles (now %b) want %0d then 0", ch, width, trigger, TC);
        end
        w_cyc = cyc;
        case (kind)
            0: begin
                repeat (d) @(negedge clk);
                echo[ch] = 1'b1;
                for (int i = 0; i < len; i++) begin
                    @(negedge clk);
                    if (drop_en && i == len / 2) enable = 1'b0;
                end
                echo[ch] = 1'b0;
                ed = 16'(len / CPC); es = 2'b01; exp_lat = d + len + 3;
            end
            1: begin ed = 16'hFFFF; es = 2'b00; exp_lat = ET; end
            default: begin ed = 16'hFFFF; es = 2'b10; exp_lat = 1; end
        endcase
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            seen = (sample_done === 1'b1);
        end
        total++;
        if (!seen) begin bad++; $display("FAIL sample_done_wait ch%0d: got no pulse want one", ch); return; end
        last_done_cyc = cyc;
        total++;
        if (cyc - w_cyc != exp_lat) begin
            bad++;
            $display("FAIL result_latency ch%0d kind%0d: got %0d want %0d", ch, kind, cyc - w_cyc, exp_lat);
        end
        total++;
        if (sample_id !== 2'(ch)) begin bad++; $display("FAIL sample_id: got %0d want %0d", sample_id, ch); end
        m_dist[ch] = ed;
        m_stat[ch] = es;
        read_all_results("readback");
        @(negedge clk);
        total++;
        if (sample_done !== 1'b0) begin bad++; $display("FAIL sample_done_width: got %b want 0", sample_done); end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (trigger !== '0 || busy !== 1'b0 || sample_done !== 1'b0 || sample_id !== 2'd0) begin
            bad++;
            $display("FAIL reset_outputs: got trig=%b busy=%b done=%b id=%0d want 0", trigger, busy, sample_done, sample_id);
        end
        read_all_results("reset");
        enable = 1'b1;
        repeat (10) @(negedge clk);
        total++;
        if (busy !== 1'b0 || trigger !== '0) begin bad++; $display("FAIL empty_mask_idle: got busy=%b trig=%b want 0", busy, trigger); end
    endtask

    task automatic test_first_ping();
        int ch, t;
        do_reset();
        sensor_mask = 4'b1111;
        enable = 1'b1;
        ping(0, 5, 57, 1'b0);
        total++;
        if (m_dist[0] !== 16'd5) begin bad++; $display("FAIL first_dist: got %0d want 5", m_dist[0]); end
        wait_trigger(ch, t);
        total++;
        if (ch != 1) begin bad++; $display("FAIL second_trigger: got ch%0d want ch1", ch); end
    endtask

    task automatic test_mask_order();
        do_reset();
        sensor_mask = 4'b1010;
        enable = 1'b1;
        for (int i = 0; i < 4; i++)
            ping(0, int'($urandom_range(0, 8)), (i < 2) ? 30 : int'($urandom_range(12, 150)), 1'b0);
    endtask

    task automatic test_timeout_guard();
        int done2;
        do_reset();
        sensor_mask = 4'b1111;
        enable = 1'b1;
        ping(0, int'($urandom_range(0, 8)), int'($urandom_range(12, 150)), 1'b0);
        ping(0, int'($urandom_range(0, 8)), int'($urandom_range(12, 150)), 1'b0);
        ping(1, 0, 0, 1'b0);
        done2 = last_done_cyc;
        ping(0, int'($urandom_range(0, 8)), int'($urandom_range(12, 150)), 1'b0);
        total++;
        if (last_trig_cyc - done2 != GC) begin
            bad++;
            $display("FAIL guard_gap: got %0d cycles want %0d", last_trig_cyc - done2, GC);
        end
    endtask

    task automatic test_stuck_echo();
        do_reset();
        echo[1] = 1'b1;
        sensor_mask = 4'b1111;
        enable = 1'b1;
        ping(0, int'($urandom_range(0, 8)), int'($urandom_range(12, 150)), 1'b0);
        ping(2, 0, 0, 1'b0);
        echo[1] = 1'b0;
        ping(0, int'($urandom_range(0, 8)), int'($urandom_range(12, 150)), 1'b0);
    endtask

    task automatic test_enable_drop_and_reset();
        int ch, t, s;
        bit quiet;
        do_reset();
        sensor_mask = 4'b1111;
        enable = 1'b1;
        ping(0, 3, 64, 1'b1);
        s = last_done_cyc;
        while (cyc < s + GC - 1) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL guard_busy: got %b want 1", busy); end
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL idle_after_guard: got busy=%b want 0", busy); end
        quiet = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (trigger !== '0 || busy !== 1'b0 || sample_done !== 1'b0) quiet = 1'b0;
        end
        total++;
        if (!quiet) begin bad++; $display("FAIL stays_idle: got activity with enable=0 want none"); end
        enable = 1'b1;
        wait_trigger(ch, t);
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if (trigger !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_trig: got trig=%b busy=%b want 0", trigger, busy);
        end
        for (int i = 0; i < NS; i++) begin m_dist[i] = 16'hFFFF; m_stat[i] = 2'b00; end
        read_all_results("reset_mid_trig");
        @(negedge clk);
        reset = 1'b0;
        enable = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        last_trig_cyc = 0;
        last_done_cyc = 0;
        test_reset();
        test_first_ping();
        test_mask_order();
        test_timeout_guard();
        test_stuck_echo();
        test_enable_drop_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
